// File: rtl/reservation_station.sv
// Tomasulo reservation station bank: issue, CDB snoop, dispatch to one FU.
// Entries are freed when their own station tag is broadcast on the CDB.
module reservation_station #(
  parameter int         DEPTH       = 4,
  parameter logic [4:0] TAG_BASE    = 5'd0,
  parameter logic [4:0] INVALID_TAG = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_issue_valid,
  output logic        out_issue_ready,
  output logic [4:0]  out_alloc_tag,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_val_1,
  input  logic [31:0] in_val_2,
  input  logic [4:0]  in_tag_1,
  input  logic [4:0]  in_tag_2,
  input  logic        in_CDB_broadcast,
  input  logic [4:0]  in_CDB_tag,
  input  logic [31:0] in_CDB_val,
  output logic        out_fu_valid,
  input  logic        in_fu_ready,
  output logic [3:0]  out_fu_op,
  output logic [31:0] out_fu_a,
  output logic [31:0] out_fu_b,
  output logic [4:0]  out_fu_tag
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    FREE, WAIT, READY, EXEC
  } ent_st_t;

  ent_st_t     st_q [DEPTH];
  logic [3:0]  op_q [DEPTH];
  logic [31:0] v1_q [DEPTH];
  logic [31:0] v2_q [DEPTH];
  logic [4:0]  t1_q [DEPTH];
  logic [4:0]  t2_q [DEPTH];

  logic [IW-1:0]    alloc_idx;
  logic [IW-1:0]    sel_idx;
  logic             any_free;
  logic             any_ready;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic             byp1;
  logic             byp2;
  logic [31:0]      nv1;
  logic [31:0]      nv2;
  logic [4:0]       nt1;
  logic [4:0]       nt2;
  logic             issue_fire;
  logic             fu_fire;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    alloc_idx = '0;
    sel_idx   = '0;
    any_free  = 1'b0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        alloc_idx = IW'(i);
        any_free  = 1'b1;
      end
      if (st_q[i] == READY) begin
        sel_idx   = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

  // Ready operands carry INVALID_TAG and must never match a broadcast.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = in_CDB_broadcast && st_q[i] == WAIT &&
                t1_q[i] == in_CDB_tag && t1_q[i] != INVALID_TAG;
      hit2[i] = in_CDB_broadcast && st_q[i] == WAIT &&
                t2_q[i] == in_CDB_tag && t2_q[i] != INVALID_TAG;
    end
  end

  always_comb begin
    byp1 = in_CDB_broadcast && in_tag_1 == in_CDB_tag &&
           in_tag_1 != INVALID_TAG;
    byp2 = in_CDB_broadcast && in_tag_2 == in_CDB_tag &&
           in_tag_2 != INVALID_TAG;
    nv1  = byp1 ? in_CDB_val : in_val_1;
    nv2  = byp2 ? in_CDB_val : in_val_2;
    nt1  = byp1 ? INVALID_TAG : in_tag_1;
    nt2  = byp2 ? INVALID_TAG : in_tag_2;
  end

  assign issue_fire      = in_issue_valid && any_free;
  assign fu_fire         = in_fu_ready && any_ready;
  assign out_issue_ready = any_free;
  assign out_alloc_tag   = TAG_BASE + 5'(alloc_idx);
  assign out_fu_valid    = any_ready;
  assign out_fu_op  = any_ready ? op_q[sel_idx] : 4'd0;
  assign out_fu_a   = any_ready ? v1_q[sel_idx] : 32'd0;
  assign out_fu_b   = any_ready ? v2_q[sel_idx] : 32'd0;
  assign out_fu_tag = any_ready ? TAG_BASE + 5'(sel_idx)
                                : INVALID_TAG;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= FREE;
        op_q[i] <= '0;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
        t1_q[i] <= INVALID_TAG;
        t2_q[i] <= INVALID_TAG;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        unique case (st_q[i])
          FREE: begin
            if (issue_fire && alloc_idx == IW'(i)) begin
              op_q[i] <= in_op;
              v1_q[i] <= nv1;
              v2_q[i] <= nv2;
              t1_q[i] <= nt1;
              t2_q[i] <= nt2;
              st_q[i] <= (nt1 == INVALID_TAG && nt2 == INVALID_TAG)
                         ? READY : WAIT;
            end
          end
          WAIT: begin
            if (hit1[i]) begin
              v1_q[i] <= in_CDB_val;
              t1_q[i] <= INVALID_TAG;
            end
            if (hit2[i]) begin
              v2_q[i] <= in_CDB_val;
              t2_q[i] <= INVALID_TAG;
            end
            if ((hit1[i] || t1_q[i] == INVALID_TAG) &&
                (hit2[i] || t2_q[i] == INVALID_TAG))
              st_q[i] <= READY;
          end
          READY: begin
            if (fu_fire && sel_idx == IW'(i))
              st_q[i] <= EXEC;
          end
          EXEC: begin
            if (in_CDB_broadcast &&
                in_CDB_tag == TAG_BASE + 5'(i))
              st_q[i] <= FREE;
          end
          default: st_q[i] <= FREE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected dispatches are
// queued at stimulus time and compared on each FU handshake.
module tb_reservation_station;

  localparam logic [4:0] INV = 5'b11111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_issue_valid = 1'b0;
  logic        out_issue_ready;
  logic [4:0]  out_alloc_tag;
  logic [3:0]  in_op = '0;
  logic [31:0] in_val_1 = '0;
  logic [31:0] in_val_2 = '0;
  logic [4:0]  in_tag_1 = INV;
  logic [4:0]  in_tag_2 = INV;
  logic        in_CDB_broadcast = 1'b0;
  logic [4:0]  in_CDB_tag = '0;
  logic [31:0] in_CDB_val = '0;
  logic        out_fu_valid;
  logic        in_fu_ready = 1'b0;
  logic [3:0]  out_fu_op;
  logic [31:0] out_fu_a;
  logic [31:0] out_fu_b;
  logic [4:0]  out_fu_tag;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
  } disp_t;

  disp_t sb[$];
  int    errors = 0;
  int    checks = 0;

  reservation_station dut (
    .clk(clk), .rst(rst),
    .in_issue_valid(in_issue_valid),
    .out_issue_ready(out_issue_ready),
    .out_alloc_tag(out_alloc_tag),
    .in_op(in_op),
    .in_val_1(in_val_1), .in_val_2(in_val_2),
    .in_tag_1(in_tag_1), .in_tag_2(in_tag_2),
    .in_CDB_broadcast(in_CDB_broadcast),
    .in_CDB_tag(in_CDB_tag), .in_CDB_val(in_CDB_val),
    .out_fu_valid(out_fu_valid),
    .in_fu_ready(in_fu_ready),
    .out_fu_op(out_fu_op),
    .out_fu_a(out_fu_a), .out_fu_b(out_fu_b),
    .out_fu_tag(out_fu_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag);
    disp_t d;
    d.op = op; d.a = a; d.b = b; d.tag = tag;
    sb.push_back(d);
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] v1, input logic [4:0] t1,
                       input logic [31:0] v2, input logic [4:0] t2);
    in_issue_valid = 1'b1;
    in_op = op;
    in_val_1 = v1; in_tag_1 = t1;
    in_val_2 = v2; in_tag_2 = t2;
    cyc();
    in_issue_valid = 1'b0;
    in_tag_1 = INV; in_tag_2 = INV;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
    in_CDB_broadcast = 1'b1;
    in_CDB_tag = tag;
    in_CDB_val = val;
    cyc();
    in_CDB_broadcast = 1'b0;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_issue_ready"}, 32'(out_issue_ready), 32'd1);
    chk({pfx, "_alloc_tag"}, 32'(out_alloc_tag), 32'd0);
    chk({pfx, "_fu_valid"}, 32'(out_fu_valid), 32'd0);
    chk({pfx, "_fu_op"}, 32'(out_fu_op), 32'd0);
    chk({pfx, "_fu_a"}, out_fu_a, 32'd0);
    chk({pfx, "_fu_b"}, out_fu_b, 32'd0);
    chk({pfx, "_fu_tag"}, 32'(out_fu_tag), 32'(INV));
  endtask

  always @(negedge clk) begin
    if (!rst && out_fu_valid && in_fu_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_dispatch", 32'(out_fu_tag), 32'(INV));
      end else begin
        disp_t e;
        e = sb.pop_front();
        chk("disp_op", 32'(out_fu_op), 32'(e.op));
        chk("disp_a", out_fu_a, e.a);
        chk("disp_b", out_fu_b, e.b);
        chk("disp_tag", 32'(out_fu_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk_reset_outs("rst");
    cyc();
    rst = 1'b0;
    cyc();

    // Ready-at-issue dispatch, then free by own tag
    chk("t1_alloc", 32'(out_alloc_tag), 32'd0);
    issue(4'd3, 32'd5, INV, 32'd7, INV);
    push(4'd3, 32'd5, 32'd7, 5'd0);
    chk("t1_fu_valid", 32'(out_fu_valid), 32'd1);
    chk("t1_fu_tag", 32'(out_fu_tag), 32'd0);
    in_fu_ready = 1'b1;
    cyc();
    in_fu_ready = 1'b0;
    chk("t1_exec_valid", 32'(out_fu_valid), 32'd0);
    chk("t1_exec_alloc", 32'(out_alloc_tag), 32'd1);
    cdb(5'd0, 32'h1234);
    chk("t1_freed_ready", 32'(out_issue_ready), 32'd1);
    chk("t1_freed_alloc", 32'(out_alloc_tag), 32'd0);

    // Wait on tag 9; INVALID_TAG broadcast must not disturb operands
    issue(4'd1, 32'd0, 5'd9, 32'h11, INV);
    chk("t2_wait_valid", 32'(out_fu_valid), 32'd0);
    cdb(INV, 32'h55);
    chk("t2_inv_valid", 32'(out_fu_valid), 32'd0);
    cdb(5'd9, 32'hDEAD);
    push(4'd1, 32'hDEAD, 32'h11, 5'd0);
    chk("t2_snoop_valid", 32'(out_fu_valid), 32'd1);
    in_fu_ready = 1'b1;
    cyc();
    in_fu_ready = 1'b0;
    cdb(5'd0, 32'd0);

    // Issue-time bypass on both operands
    in_CDB_broadcast = 1'b1;
    in_CDB_tag = 5'd9;
    in_CDB_val = 32'd42;
    issue(4'd2, 32'd1, 5'd9, 32'd2, 5'd9);
    in_CDB_broadcast = 1'b0;
    push(4'd2, 32'd42, 32'd42, 5'd0);
    chk("t3_byp_valid", 32'(out_fu_valid), 32'd1);
    in_fu_ready = 1'b1;
    cyc();
    in_fu_ready = 1'b0;
    cdb(5'd0, 32'd0);

    // Fill all entries, drop a fifth issue, free tag 2
    for (int i = 0; i < 4; i++) begin
      chk("t4_alloc", 32'(out_alloc_tag), 32'(i));
      issue(4'(i + 4), 32'(100 + i), INV, 32'(200 + i), INV);
      push(4'(i + 4), 32'(100 + i), 32'(200 + i), 5'(i));
    end
    chk("t4_full", 32'(out_issue_ready), 32'd0);
    issue(4'd15, 32'hBAD, INV, 32'hBAD, INV);
    chk("t4_still_full", 32'(out_issue_ready), 32'd0);
    in_fu_ready = 1'b1;
    repeat (5) cyc();
    in_fu_ready = 1'b0;
    chk("t4_drained", 32'(out_fu_valid), 32'd0);
    cdb(5'd2, 32'd0);
    chk("t4_free2_ready", 32'(out_issue_ready), 32'd1);
    chk("t4_free2_alloc", 32'(out_alloc_tag), 32'd2);
    cdb(5'd0, 32'd0);
    cdb(5'd1, 32'd0);
    cdb(5'd3, 32'd0);
    chk("t4_all_free", 32'(out_alloc_tag), 32'd0);

    // Stalled FU holds selection, then in-order by index
    issue(4'd8, 32'd11, INV, 32'd12, INV);
    push(4'd8, 32'd11, 32'd12, 5'd0);
    issue(4'd9, 32'd21, INV, 32'd22, INV);
    push(4'd9, 32'd21, 32'd22, 5'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_tag", 32'(out_fu_tag), 32'd0);
      cyc();
    end
    in_fu_ready = 1'b1;
    cyc();
    chk("t5_next_tag", 32'(out_fu_tag), 32'd1);
    cyc();
    in_fu_ready = 1'b0;
    cdb(5'd0, 32'd0);
    cdb(5'd1, 32'd0);

    // Async reset with one EXEC and one WAIT entry
    issue(4'd6, 32'd1, INV, 32'd2, INV);
    push(4'd6, 32'd1, 32'd2, 5'd0);
    in_fu_ready = 1'b1;
    cyc();
    in_fu_ready = 1'b0;
    issue(4'd7, 32'd3, 5'd20, 32'd4, INV);
    chk("t6_pre_alloc", 32'(out_alloc_tag), 32'd2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("t6");
    cyc();
    rst = 1'b0;
    cyc();
    issue(4'd5, 32'hAA, INV, 32'hBB, INV);
    push(4'd5, 32'hAA, 32'hBB, 5'd0);
    in_fu_ready = 1'b1;
    cyc();
    in_fu_ready = 1'b0;
    cyc();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Tomasulo reservation station bank between the register status table and one functional unit. Accepts issued instructions with the operand value/tag pairs the register status table produces, allocates each a unique station tag (fed back to the register status table as its bank tag), snoops the CDB for pending operands, and dispatches ready entries to the FU. An entry is freed when its own tag is broadcast on the CDB.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_BASE, 5'd0, tag of entry 0; entry i owns tag TAG_BASE+i; TAG_BASE+DEPTH-1 < 31
- INVALID_TAG, 5'b11111, operand-ready marker (matches register status convention)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_issue_valid  in  1  issue request this cycle
- out_issue_ready  out  1  at least one FREE entry
- out_alloc_tag  out  5  tag the next accepted issue receives
- in_op  in  4  FU opcode
- in_val_1, in_val_2  in  32  operand values (meaningful when tag == INVALID_TAG)
- in_tag_1, in_tag_2  in  5  producing tags, INVALID_TAG if ready
- in_CDB_broadcast  in  1  CDB valid, one-cycle level, sampled at clk edge
- in_CDB_tag  in  5  broadcasting tag
- in_CDB_val  in  32  broadcast value
- out_fu_valid  out  1  dispatch request
- in_fu_ready  in  1  FU accepts
- out_fu_op  out  4  opcode of dispatched entry
- out_fu_a, out_fu_b  out  32  operand values
- out_fu_tag  out  5  station tag of dispatched entry (FU broadcasts result under it)

## Operation
- Per-entry state: FREE -> WAIT (issued, some operand tag != INVALID_TAG) or READY (both ready) -> EXEC (dispatched) -> FREE (own tag on CDB).
- Issue accepted when in_issue_valid && out_issue_ready; written into lowest-index FREE entry; out_alloc_tag = that entry's tag (combinational from free vector; TAG_BASE when all free; unchanged value when full, ignore).
- Issue while full: dropped, no state change.
- Issue-time bypass: if in_CDB_broadcast and in_tag_k == in_CDB_tag (k = 1,2), operand k stored as in_CDB_val with INVALID_TAG; entry enters READY if both then ready.
- CDB snoop: every WAIT entry with operand tag == in_CDB_tag captures in_CDB_val and sets tag INVALID_TAG; both operands may capture from one broadcast. WAIT -> READY when both tags INVALID_TAG.
- in_CDB_tag == INVALID_TAG or outside this station's range: no free; snoop still compares but INVALID_TAG operands are never overwritten.
- Free: in_CDB_broadcast with in_CDB_tag == entry tag and entry in EXEC -> FREE. Broadcast of own tag for a non-EXEC entry is ignored.
- Dispatch select: lowest-index READY entry. out_fu_valid = any READY; outputs are combinational from selected entry; on in_fu_ready && out_fu_valid entry -> EXEC.
- Outputs while out_fu_valid=0: out_fu_op/a/b = 0, out_fu_tag = INVALID_TAG.
- Selection is stable only while no lower-index entry becomes READY; FU samples only on the handshake cycle.

## Timing
- Reset (async, immediate): all entries FREE, out_issue_ready=1, out_alloc_tag=TAG_BASE, out_fu_valid=0, out_fu_op/a/b=0, out_fu_tag=INVALID_TAG. Reset mid-operation discards all entries including EXEC.
- Issue at edge N with both operands ready -> out_fu_valid=1 during cycle N+1 (one-cycle issue-to-dispatch latency). No same-cycle issue-to-dispatch bypass.
- CDB capture at edge N -> dispatch-eligible in cycle N+1.
- Entry freed at edge N -> out_issue_ready/out_alloc_tag reflect it in cycle N+1; not reusable in cycle N.
- Simultaneous issue, CDB snoop, dispatch, free in one cycle are independent and all take effect at the same edge.
- Back-to-back issue: one per cycle while not full; DEPTH issues fill the station.

## Test plan
- Reset, issue op=3, val_1=5, val_2=7, tags INVALID -> alloc_tag 0; next cycle out_fu_valid=1, a=5, b=7, tag=0; fu_ready -> entry EXEC; CDB tag 0 -> out_issue_ready stays 1, entry reusable.
- Issue with tag_1=9 -> no dispatch; CDB tag 9 val 0xDEAD -> next cycle out_fu_valid=1, a=0xDEAD.
- Issue tag_1=tag_2=9 same cycle as CDB tag 9 val 42 -> stored ready, dispatch next cycle a=b=42.
- Four issues back-to-back -> alloc_tags 0,1,2,3, out_issue_ready=0; fifth issue dropped; free tag 2 -> next alloc_tag 2.
- Entries 0 and 1 READY, fu_ready=0 for 3 cycles -> out_fu_tag held 0; fu_ready=1 -> tag 0 then tag 1.
- Assert rst while entry in EXEC and one in WAIT -> all outputs at reset values immediately, alloc_tag 0.
